pe_wrapper: RTL and testbench
=============================

PE_WRAPPER -- requirements
Module: pe_wrapper

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports are named as in the codebase: clk_0 (clock) and rst_n_0 (reset, active-high despite its name).
REQ-002 clk_0  in  1  rising-edge clock for all logic.
REQ-003 rst_n_0  in  1  synchronous active-high reset.
REQ-004 cfg_we_0  in  1  config register write strobe.
REQ-005 cfg_addr_0  in  4  config register address for both write and read.
REQ-006 cfg_wdata_0  in  32  config write data.
REQ-007 cfg_rdata_0  out  32  combinational read of the register at cfg_addr_0.
REQ-008 addra_0 / dina_0 / wea_0  in  16 / 128 / 1  weight buffer write port.
REQ-009 addra_1 / dina_1 / wea_1  in  16 / 128 / 1  activation buffer write port.
REQ-010 addrb_0  in  10  psum buffer read address.
REQ-011 doutb_0  out  512  psum buffer read data, 16 lanes x 32 bit; lane c occupies bits [c*32+31:c*32].

Function
REQ-012 Register map:
- 0 control: write bit0=1 issues start; reads 0.
- 1 status, read-only: bit0 done, bit1 busy.
- 2 kernel: KH[11:8], KW[3:0].
- 3 input size: IN_H[15:8], IN_W[7:0].
- 4 stride/padding: PAD[7:4], STRIDE[3:0].
- 5 output size: OUT_H[15:8], OUT_W[7:0].
- All other addresses read 0 and ignore writes.
- Registers 2-5 read back the stored fields; all other bits read 0.
REQ-013 Config writes are sampled on the rising edge when cfg_we_0=1.
REQ-014 Weight buffer: 1024 x 128 bit, indexed by addra_0[9:0], written on the clock edge when wea_0=1. Byte k is the int8 weight for input channel k. Word address = (ky*KW+kx)*16 + oc.
REQ-015 Activation buffer: 4096 x 128 bit, indexed by addra_1[11:0], written on the clock edge when wea_1=1. Byte k is the int8 activation for channel k at address iy*IN_W+ix.
REQ-016 Psum buffer: 1024 x 512 bit, one word per output pixel at address oy*OUT_W+ox. doutb_0 is registered, so data for addrb_0 appears one clock after the address is presented.
REQ-017 Compute result for each oy<OUT_H, ox<OUT_W, oc<16: out = sum over ky<KH, kx<KW, k<16 of act[iy][ix][k] * w[ky][kx][k][oc].
- iy = oy*STRIDE+ky-PAD and ix = ox*STRIDE+kx-PAD.
- Taps with iy or ix outside [0,IN_H) or [0,IN_W) contribute 0.
REQ-018 Arithmetic: signed 8x8 products; 32-bit two's-complement accumulation that wraps on overflow.
REQ-019 State machine: IDLE -> RUN on start -> WRITE (per pixel) -> RUN or DONE.
- RUN performs one (pixel, ky, kx, oc) 16-lane dot product per cycle, with pipelined buffer reads allowed.
- WRITE stores the 16 accumulators into the psum buffer and clears them.
- DONE returns to IDLE, with status done=1, busy=0.
REQ-020 busy=1 from the cycle after start until the last psum write has committed. done is set only after that write, so psum reads are valid whenever done=1.
REQ-021 done stays 1 until the next start. A start clears done and sets busy.
REQ-022 A start while busy=1 is ignored.
REQ-023 Buffer writes during a computation are permitted but give undefined results.
REQ-024 Results for lanes oc whose weight words were never written are undefined. Lanes with written weights are exact.
REQ-025 Total compute SHALL take at most OUT_H*OUT_W*(KH*KW*16+8) + 16 cycles.
REQ-026 Config values outside buffer capacity give undefined results, but the state machine SHALL still terminate. This covers OUT_H*OUT_W > 1024, IN_H*IN_W > 4096 and KH*KW > 64.
REQ-027 A zero value in KH, KW, OUT_H or OUT_W SHALL complete immediately with done=1 and no psum writes.

Reset
REQ-028 On reset: state=IDLE, done=0, busy=0, registers 2-5 = 0, accumulators = 0, doutb_0 = 0.
REQ-029 Buffer contents are not cleared by reset.
REQ-030 Reset mid-computation aborts it immediately and leaves psum contents partially updated.
REQ-031 cfg_rdata_0 for address 1 reads 0 in the cycle after reset.

Verification
REQ-032 Random case, weights and activations in [-4,4]: CIN=16, KH=KW=3, 8x8 input, stride 1, pad 1, 8x8 output. Load weights, load activations, configure, start -> done within 100000 cycles; all 64x10 lanes oc<10 match the golden convolution, with non-zero results present.
REQ-033 1x1 kernel, stride 1, pad 0, 2x2 input, all activations=1, weight lane oc = oc -> doutb_0 lane oc = 16*oc at every pixel.
REQ-034 3x3 kernel, stride 2, pad 1, 8x8 input -> 4x4 output; corner pixel (0,0) excludes the row and column -1 taps and matches golden.
REQ-035 Write registers 2-5, then read them back -> exact field values. Status reads busy=1 during compute, then 0x1 at completion.
REQ-036 Start issued while busy -> no restart; the single done pulse arrives at the original completion time. A second start after done -> done clears, then reasserts with identical results.
REQ-037 Assert rst_n_0 mid-compute -> status=0 the next cycle. A fresh start afterwards completes correctly.

Source files
------------

// File: rtl/pe_wrapper.sv
// -----------------------------------------------------------------------------
// pe_wrapper
//
// Int8 convolution engine with on-chip weight, activation and partial-sum
// buffers, controlled through a small configuration register file.
//
// For every output pixel (oy, ox) and output channel oc it accumulates
//   sum_{ky,kx,k} act[iy][ix][k] * w[ky][kx][k][oc]
// with iy = oy*STRIDE+ky-PAD, ix = ox*STRIDE+kx-PAD. Taps outside the input
// contribute nothing. Products are signed 8x8; accumulation is 32-bit wrapping.
// Each compute cycle evaluates one 16-channel dot product for one
// (pixel, ky, kx, oc) tap. After all taps of a pixel the 16 accumulators are
// written as one psum word at oy*OUT_W+ox and cleared.
//
// Ports
//   clk_0        in   1    rising-edge clock
//   rst_n_0      in   1    synchronous reset, active HIGH despite the name
//   cfg_we_0     in   1    config register write strobe
//   cfg_addr_0   in   4    config register address (write and read)
//   cfg_wdata_0  in   32   config write data
//   cfg_rdata_0  out  32   combinational read of register cfg_addr_0
//   addra_0      in   16   weight buffer write address (bits [9:0] used)
//   dina_0       in   128  weight word, byte k = input channel k
//   wea_0        in   1    weight buffer write enable
//   addra_1      in   16   activation buffer write address (bits [11:0] used)
//   dina_1       in   128  activation word, byte k = channel k
//   wea_1        in   1    activation buffer write enable
//   addrb_0      in   10   psum buffer read address
//   doutb_0      out  512  registered psum word, lane c at [c*32+31:c*32]
//
// Register map
//   0 control  write bit0=1 starts a computation (ignored while busy); reads 0
//   1 status   bit0 done, bit1 busy
//   2 kernel   KH[11:8] KW[3:0]
//   3 input    IN_H[15:8] IN_W[7:0]
//   4 stride   PAD[7:4] STRIDE[3:0]
//   5 output   OUT_H[15:8] OUT_W[7:0]
// -----------------------------------------------------------------------------
module pe_wrapper (
    input  logic         clk_0,
    input  logic         rst_n_0,
    input  logic         cfg_we_0,
    input  logic [3:0]   cfg_addr_0,
    input  logic [31:0]  cfg_wdata_0,
    output logic [31:0]  cfg_rdata_0,
    input  logic [15:0]  addra_0,
    input  logic [127:0] dina_0,
    input  logic         wea_0,
    input  logic [15:0]  addra_1,
    input  logic [127:0] dina_1,
    input  logic         wea_1,
    input  logic [9:0]   addrb_0,
    output logic [511:0] doutb_0
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Configuration registers
    logic [3:0] kh, kw, pad, stride;
    logic [7:0] in_h, in_w, out_h, out_w;

    // Control state
    logic [2:0] state;
    logic       busy, done;

    // Loop counters; tap tracks ky*KW+kx, pix tracks oy*OUT_W+ox
    logic [7:0] oy, ox, tap;
    logic [3:0] ky, kx, oc;
    logic [9:0] pix;

    // Read pipeline stage between buffer read and accumulate
    logic         p_valid, p_inr;
    logic [3:0]   p_oc;
    logic [127:0] w_q, a_q;

    logic [15:0][31:0] acc;

    // Buffers
    logic [127:0] wbuf [1024];
    logic [127:0] abuf [4096];
    logic [511:0] pbuf [1024];

    // -------------------------------------------------------------------------
    // Decode and loop-end flags. Comparisons use ">=" so that a config change
    // in the middle of a run still lets every loop reach its end.
    // -------------------------------------------------------------------------
    logic start_req, zero_cfg;
    logic oc_last, kx_last, ky_last, ox_last, oy_last;

    assign start_req = cfg_we_0 && (cfg_addr_0 == 4'd0) && cfg_wdata_0[0];
    assign zero_cfg  = (kh == 4'd0) || (kw == 4'd0) || (out_h == 8'd0) || (out_w == 8'd0);
    assign oc_last   = (oc == 4'hF);
    assign kx_last   = ({1'b0, kx} + 5'd1) >= {1'b0, kw};
    assign ky_last   = ({1'b0, ky} + 5'd1) >= {1'b0, kh};
    assign ox_last   = ({1'b0, ox} + 9'd1) >= {1'b0, out_w};
    assign oy_last   = ({1'b0, oy} + 9'd1) >= {1'b0, out_h};

    // -------------------------------------------------------------------------
    // Address generation. iy/ix are held in 16-bit two's complement so a
    // negative coordinate from padding shows up as bit 15 set.
    // -------------------------------------------------------------------------
    logic [15:0] iy_u, ix_u, a_full;
    logic [11:0] w_full;
    logic [11:0] a_addr;
    logic [9:0]  w_addr;
    logic        in_range;

    // NOTE: always_comb gives every output a default first, so no path can leave a value held and infer a latch.
    always_comb begin
        iy_u     = '0;
        ix_u     = '0;
        a_full   = '0;
        w_full   = '0;
        in_range = 1'b0;
        iy_u     = {8'd0, oy} * {12'd0, stride} + {12'd0, ky} - {12'd0, pad};
        ix_u     = {8'd0, ox} * {12'd0, stride} + {12'd0, kx} - {12'd0, pad};
        in_range = !iy_u[15] && !ix_u[15] && (iy_u < {8'd0, in_h}) && (ix_u < {8'd0, in_w});
        a_full   = iy_u * {8'd0, in_w} + ix_u;
        w_full   = {tap, oc};
    end

    assign a_addr = a_full[11:0];
    assign w_addr = w_full[9:0];

    // -------------------------------------------------------------------------
    // 16-lane signed dot product of the registered buffer words
    // -------------------------------------------------------------------------
    logic signed [15:0] prod;
    logic        [31:0] dot;

    always_comb begin
        dot  = '0;
        prod = '0;
        for (int k = 0; k < 16; k++) begin
            prod = $signed(a_q[k*8 +: 8]) * $signed(w_q[k*8 +: 8]);
            dot  = dot + {{16{prod[15]}}, prod};
        end
    end

    // -------------------------------------------------------------------------
    // Buffers
    // -------------------------------------------------------------------------
    // NOTE: buffer storage carries no reset; contents survive reset and only the control state is cleared.
    always_ff @(posedge clk_0) begin
        if (wea_0) wbuf[addra_0[9:0]] <= dina_0;
        if (wea_1) abuf[addra_1[11:0]] <= dina_1;
        // A reset arriving on a write cycle aborts that write too.
        if ((state == ST_WRITE) && !rst_n_0) pbuf[pix] <= acc;
        w_q <= wbuf[w_addr];
        a_q <= abuf[a_addr];
    end

    always_ff @(posedge clk_0) begin
        if (rst_n_0) doutb_0 <= '0;
        else         doutb_0 <= pbuf[addrb_0];
    end

    // -------------------------------------------------------------------------
    // Config registers, FSM, counters, accumulators
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_0) begin
        if (rst_n_0) begin
            kh <= '0; kw <= '0; in_h <= '0; in_w <= '0;
            pad <= '0; stride <= '0; out_h <= '0; out_w <= '0;
            state <= ST_IDLE;
            busy <= 1'b0; done <= 1'b0;
            oy <= '0; ox <= '0; ky <= '0; kx <= '0; oc <= '0; tap <= '0; pix <= '0;
            p_valid <= 1'b0; p_inr <= 1'b0; p_oc <= '0;
            acc <= '0;
        end else begin
            if (cfg_we_0) begin
                case (cfg_addr_0)
                    4'd2: begin kh <= cfg_wdata_0[11:8]; kw <= cfg_wdata_0[3:0]; end
                    4'd3: begin in_h <= cfg_wdata_0[15:8]; in_w <= cfg_wdata_0[7:0]; end
                    4'd4: begin pad <= cfg_wdata_0[7:4]; stride <= cfg_wdata_0[3:0]; end
                    4'd5: begin out_h <= cfg_wdata_0[15:8]; out_w <= cfg_wdata_0[7:0]; end
                    default: ;
                endcase
            end

            // Tap issued this cycle is accumulated one cycle later.
            p_valid <= (state == ST_RUN);
            p_inr   <= in_range;
            p_oc    <= oc;
            if (p_valid && p_inr) acc[p_oc] <= acc[p_oc] + dot;

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        busy <= 1'b1;
                        done <= 1'b0;
                        oy <= '0; ox <= '0; ky <= '0; kx <= '0; oc <= '0;
                        tap <= '0; pix <= '0;
                        acc <= '0;
                        state <= zero_cfg ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    oc <= oc + 4'd1;
                    if (oc_last) begin
                        if (kx_last) begin
                            kx <= '0;
                            if (ky_last) begin
                                ky    <= '0;
                                tap   <= '0;
                                state <= ST_DRAIN;
                            end else begin
                                ky  <= ky + 4'd1;
                                tap <= tap + 8'd1;
                            end
                        end else begin
                            kx  <= kx + 4'd1;
                            tap <= tap + 8'd1;
                        end
                    end
                end
                // Lets the final tap of the pixel land in its accumulator.
                ST_DRAIN: state <= ST_WRITE;
                ST_WRITE: begin
                    acc <= '0;
                    pix <= pix + 10'd1;
                    if (ox_last) begin
                        ox <= '0;
                        if (oy_last) begin
                            state <= ST_DONE;
                        end else begin
                            oy    <= oy + 8'd1;
                            state <= ST_RUN;
                        end
                    end else begin
                        ox    <= ox + 8'd1;
                        state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Register read-back
    // -------------------------------------------------------------------------
    always_comb begin
        cfg_rdata_0 = '0;
        case (cfg_addr_0)
            4'd1: cfg_rdata_0 = {30'd0, busy, done};
            4'd2: cfg_rdata_0 = {20'd0, kh, 4'd0, kw};
            4'd3: cfg_rdata_0 = {16'd0, in_h, in_w};
            4'd4: cfg_rdata_0 = {24'd0, pad, stride};
            4'd5: cfg_rdata_0 = {16'd0, out_h, out_w};
            default: ;
        endcase
    end

    // Address and data bits beyond the buffer and register sizes are not used.
    logic unused_bits;
    assign unused_bits = ^{addra_0[15:10], addra_1[15:12], cfg_wdata_0[31:16],
                           a_full[15:12], w_full[11:10]};

endmodule

// File: tb/tb_pe_wrapper.sv
`timescale 1ns/1ps
module tb_pe_wrapper;

    logic         clk_0 = 1'b0;
    logic         rst_n_0;
    logic         cfg_we_0;
    logic [3:0]   cfg_addr_0;
    logic [31:0]  cfg_wdata_0;
    logic [31:0]  cfg_rdata_0;
    logic [15:0]  addra_0, addra_1;
    logic [127:0] dina_0, dina_1;
    logic         wea_0, wea_1;
    logic [9:0]   addrb_0;
    logic [511:0] doutb_0;

    pe_wrapper dut (
        .clk_0(clk_0), .rst_n_0(rst_n_0),
        .cfg_we_0(cfg_we_0), .cfg_addr_0(cfg_addr_0),
        .cfg_wdata_0(cfg_wdata_0), .cfg_rdata_0(cfg_rdata_0),
        .addra_0(addra_0), .dina_0(dina_0), .wea_0(wea_0),
        .addra_1(addra_1), .dina_1(dina_1), .wea_1(wea_1),
        .addrb_0(addrb_0), .doutb_0(doutb_0)
    );

    always #5 clk_0 = ~clk_0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_start = 0;

    always @(posedge clk_0) cyc <= cyc + 1;

    // Behavioural model: buffer images and the current convolution shape
    byte wmem [1024][16];
    byte amem [4096][16];
    int  m_kh, m_kw, m_ih, m_iw, m_st, m_pad, m_oh, m_ow;

    initial begin
        #3ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Direct convolution straight from the definition
    function automatic int golden(input int oy, input int ox, input int oc);
        int s = 0;
        for (int ky = 0; ky < m_kh; ky++)
            for (int kx = 0; kx < m_kw; kx++) begin
                int iy = oy * m_st + ky - m_pad;
                int ix = ox * m_st + kx - m_pad;
                if (iy >= 0 && iy < m_ih && ix >= 0 && ix < m_iw)
                    for (int k = 0; k < 16; k++)
                        s += int'(amem[iy * m_iw + ix][k]) * int'(wmem[(ky * m_kw + kx) * 16 + oc][k]);
            end
        return s;
    endfunction

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        cfg_addr_0 = a; cfg_wdata_0 = d; cfg_we_0 = 1'b1;
        @(posedge clk_0); #1;
        cfg_we_0 = 1'b0;
    endtask

    task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
        cfg_addr_0 = a;
        @(negedge clk_0);
        d = cfg_rdata_0;
    endtask

    task automatic load_w(input int a);
        logic [127:0] w;
        for (int k = 0; k < 16; k++) w[k*8 +: 8] = wmem[a][k];
        addra_0 = 16'(a); dina_0 = w; wea_0 = 1'b1;
        @(posedge clk_0); #1;
        wea_0 = 1'b0;
    endtask

    task automatic load_a(input int a);
        logic [127:0] w;
        for (int k = 0; k < 16; k++) w[k*8 +: 8] = amem[a][k];
        addra_1 = 16'(a); dina_1 = w; wea_1 = 1'b1;
        @(posedge clk_0); #1;
        wea_1 = 1'b0;
    endtask

    task automatic configure(input int kh, input int kw, input int ih, input int iw,
                             input int st, input int pd, input int oh, input int ow);
        cfg_write(4'd2, 32'((kh << 8) | kw));
        cfg_write(4'd3, 32'((ih << 8) | iw));
        cfg_write(4'd4, 32'((pd << 4) | st));
        cfg_write(4'd5, 32'((oh << 8) | ow));
        m_kh = kh; m_kw = kw; m_ih = ih; m_iw = iw;
        m_st = st; m_pad = pd; m_oh = oh; m_ow = ow;
    endtask

    task automatic do_start();
        cfg_write(4'd0, 32'd1);
        t_start = cyc;
    endtask

    // Polls status until done; elapsed = edges from the start edge to done.
    task automatic wait_done(output int elapsed);
        logic [31:0] s;
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < 20000) begin
            @(posedge clk_0); #1;
            n++;
            cfg_read(4'd1, s);
            seen = s[0];
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        elapsed = cyc - t_start;
    endtask

    task automatic read_pixel(input int p, output logic [511:0] d);
        addrb_0 = 10'(p);
        @(posedge clk_0); #1;
        d = doutb_0;
    endtask

    // Compares every lane of every output pixel against the model
    task automatic compare_psum(input string tag, output int nz);
        logic [511:0] d;
        nz = 0;
        for (int p = 0; p < m_oh * m_ow; p++) begin
            read_pixel(p, d);
            for (int oc = 0; oc < 16; oc++) begin
                check($sformatf("%s p%0d oc%0d", tag, p, oc), d[oc*32 +: 32],
                      32'(golden(p / m_ow, p % m_ow, oc)));
                if (d[oc*32 +: 32] != 32'd0) nz++;
            end
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 144; a++) begin
            for (int k = 0; k < 16; k++) wmem[a][k] = byte'(int'($urandom_range(8)) - 4);
            load_w(a);
        end
        for (int a = 0; a < 64; a++) begin
            for (int k = 0; k < 16; k++) amem[a][k] = byte'(int'($urandom_range(8)) - 4);
            load_a(a);
        end
    endtask

    task automatic pulse_reset();
        rst_n_0 = 1'b1;
        @(posedge clk_0); #1;
        rst_n_0 = 1'b0;
    endtask

    initial begin
        logic [31:0]  rd;
        logic [511:0] d;
        int el, el_ref, nz;

        cfg_we_0 = 0; cfg_addr_0 = 0; cfg_wdata_0 = 0;
        addra_0 = 0; addra_1 = 0; dina_0 = 0; dina_1 = 0; wea_0 = 0; wea_1 = 0;
        addrb_0 = 0; rst_n_0 = 1'b1;
        repeat (3) @(posedge clk_0);
        #1 rst_n_0 = 1'b0;

        // Reset state
        cfg_read(4'd1, rd); check("reset_status", rd, 32'd0);
        for (int r = 2; r <= 5; r++) begin
            cfg_read(4'(r), rd); check($sformatf("reset_reg%0d", r), rd, 32'd0);
        end
        check("reset_doutb", {31'd0, |doutb_0}, 32'd0);

        // Register read-back with junk in unused bits
        cfg_write(4'd2, 32'hFFFF_F3A5); cfg_read(4'd2, rd); check("reg2", rd, 32'h0000_0305);
        cfg_write(4'd3, 32'hABCD_1234); cfg_read(4'd3, rd); check("reg3", rd, 32'h0000_1234);
        cfg_write(4'd4, 32'hFFFF_FF37); cfg_read(4'd4, rd); check("reg4", rd, 32'h0000_0037);
        cfg_write(4'd5, 32'h1234_5678); cfg_read(4'd5, rd); check("reg5", rd, 32'h0000_5678);
        cfg_write(4'd6, 32'hFFFF_FFFF); cfg_read(4'd6, rd); check("reg6", rd, 32'd0);
        cfg_write(4'd0, 32'hFFFF_FFFE); cfg_read(4'd0, rd); check("reg0", rd, 32'd0);
        cfg_read(4'd1, rd); check("no_start_bit0_clear", rd, 32'd0);

        // 1x1 kernel, 2x2 input, activations 1, weight lane oc = oc
        for (int a = 0; a < 4; a++) begin
            for (int k = 0; k < 16; k++) amem[a][k] = 8'sd1;
            load_a(a);
        end
        for (int oc = 0; oc < 16; oc++) begin
            for (int k = 0; k < 16; k++) wmem[oc][k] = byte'(oc);
            load_w(oc);
        end
        configure(1, 1, 2, 2, 1, 0, 2, 2);
        do_start();
        cfg_read(4'd1, rd); check("k1_busy", rd, 32'h2);
        wait_done(el);
        cfg_read(4'd1, rd); check("k1_status_done", rd, 32'h1);
        check("k1_bound", 32'(el <= 4 * (16 + 8) + 16), 32'd1);
        compare_psum("k1", nz);
        read_pixel(3, d);
        for (int oc = 0; oc < 16; oc++)
            check($sformatf("k1_literal oc%0d", oc), d[oc*32 +: 32], 32'(16 * oc));

        // All-ones 3x3, stride 2, pad 1, 8x8 -> 4x4: literal corner/edge/interior
        for (int a = 0; a < 144; a++) begin
            for (int k = 0; k < 16; k++) wmem[a][k] = 8'sd1;
            load_w(a);
        end
        for (int a = 0; a < 64; a++) begin
            for (int k = 0; k < 16; k++) amem[a][k] = 8'sd1;
            load_a(a);
        end
        configure(3, 3, 8, 8, 2, 1, 4, 4);
        check("model_pin_corner", 32'(golden(0, 0, 0)), 32'd64);
        do_start();
        wait_done(el);
        compare_psum("ones_s2", nz);
        read_pixel(0, d); check("ones_corner", d[7*32 +: 32], 32'd64);
        read_pixel(1, d); check("ones_edge", d[3*32 +: 32], 32'd96);
        read_pixel(5, d); check("ones_inner", d[15*32 +: 32], 32'd144);

        // Random data, 3x3 stride 1 pad 1, 8x8 -> 8x8
        fill_random();
        configure(3, 3, 8, 8, 1, 1, 8, 8);
        do_start();
        repeat (200) @(posedge clk_0);
        #1 cfg_read(4'd1, rd); check("rand_busy_mid", rd, 32'h2);
        wait_done(el);
        check("rand_bound", 32'(el <= 64 * (9 * 16 + 8) + 16), 32'd1);
        cfg_read(4'd1, rd); check("rand_status_done", rd, 32'h1);
        compare_psum("rand_s1", nz);
        check("rand_nonzero", 32'(nz > 0), 32'd1);

        // Random data, stride 2: corner excludes the -1 row and column
        configure(3, 3, 8, 8, 2, 1, 4, 4);
        do_start();
        wait_done(el_ref);
        check("s2_bound", 32'(el_ref <= 16 * (9 * 16 + 8) + 16), 32'd1);
        compare_psum("rand_s2", nz);

        // Start while busy is ignored
        do_start();
        repeat (100) @(posedge clk_0);
        #1 cfg_write(4'd0, 32'd1);
        cfg_read(4'd1, rd); check("restart_ignored_status", rd, 32'h2);
        wait_done(el);
        check("restart_ignored_time", 32'(el), 32'(el_ref));
        // Second start after done
        do_start();
        cfg_read(4'd1, rd); check("restart_clears_done", rd, 32'h2);
        wait_done(el);
        check("restart_time", 32'(el), 32'(el_ref));
        compare_psum("rerun_s2", nz);

        // Reset mid-compute, then a fresh run
        do_start();
        repeat (50) @(posedge clk_0);
        #1 pulse_reset();
        cfg_read(4'd1, rd); check("midreset_status", rd, 32'd0);
        cfg_read(4'd2, rd); check("midreset_reg2", rd, 32'd0);
        configure(3, 3, 8, 8, 2, 1, 4, 4);
        do_start();
        wait_done(el);
        check("after_reset_time", 32'(el), 32'(el_ref));
        compare_psum("after_reset", nz);

        // KH=0 completes at once and leaves the psum buffer untouched
        cfg_write(4'd2, 32'h0000_0003);
        do_start();
        wait_done(el);
        check("zero_kh_fast", 32'(el <= 4), 32'd1);
        cfg_read(4'd1, rd); check("zero_kh_status", rd, 32'h1);
        compare_psum("zero_kh_nowrite", nz);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
